// File: rtl/t9990_pkg.sv
// Shared T9990 types and widths used by the VRAM fetch path.
package t9990_pkg;

  localparam int unsigned T9990_VRAM_ADDR_WIDTH = 19;
  localparam int unsigned T9990_WORD_WIDTH      = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FULL,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/t9990_sync_fifo.sv
// Single-clock FIFO with flush and a registered read port (holds on empty pop).
module t9990_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush && (level_q != LW'(DEPTH));
    do_pop   = pop && !flush && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rdata_d  = mem[rd_ptr_q];
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign level = level_q;

endmodule

// File: rtl/t9990_line_fetch_fifo.sv
// Line fetcher: one-outstanding VRAM word reads into a FIFO drained at dot rate.
module t9990_line_fetch_fifo
  import t9990_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = T9990_WORD_WIDTH,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = T9990_VRAM_ADDR_WIDTH,
  parameter int unsigned LOW_MARK   = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic                     DCLK_EN,
  input  logic                     LINE_START,
  input  logic [ADDR_WIDTH-1:0]    START_ADDR,
  input  logic [9:0]               WORD_COUNT,
  output logic                     VRAM_REQ,
  output logic [ADDR_WIDTH-1:0]    VRAM_ADDR,
  input  logic                     VRAM_ACK,
  input  logic [BIT_WIDTH-1:0]     VRAM_RDATA,
  input  logic                     VRAM_RVALID,
  output logic [BIT_WIDTH-1:0]     OUT,
  output logic                     OUT_VALID,
  output logic                     UNDERFLOW,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [9:0]            remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic                  underflow_q, underflow_d;
  logic [LW-1:0]         level;
  logic                  ack_fire, push, pop_fire, words_due;

  t9990_sync_fifo #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_n),
    .flush (LINE_START),
    .push  (push),
    .wdata (VRAM_RDATA),
    .pop   (DCLK_EN),
    .rdata (OUT),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    push        = 1'b0;
    ack_fire    = req_q && VRAM_ACK;
    pop_fire    = DCLK_EN && !LINE_START && (level != '0);
    words_due   = (remaining_q != '0) || (state_q == REQ) || (state_q == WAIT);

    case (state_q)
      IDLE, FULL: begin
        if (LINE_START) begin
          remaining_d = WORD_COUNT;
          if (WORD_COUNT != '0) begin
            addr_d  = START_ADDR;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == FULL && level <= LW'(LOW_MARK)) begin
          state_d = (remaining_q != '0) ? REQ : IDLE;
        end
      end
      REQ: begin
        if (LINE_START) begin
          addr_d      = START_ADDR;
          remaining_d = WORD_COUNT;
          // An accepted request still owes one RVALID that must be swallowed.
          if (ack_fire)                state_d = DRAIN;
          else if (WORD_COUNT == '0)   state_d = IDLE;
        end else if (ack_fire) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (LINE_START) begin
          addr_d      = START_ADDR;
          remaining_d = WORD_COUNT;
          if (VRAM_RVALID) state_d = (WORD_COUNT != '0) ? REQ : IDLE;
          else             state_d = DRAIN;
        end else if (VRAM_RVALID) begin
          push = 1'b1;
          if (remaining_q == '0)                             state_d = IDLE;
          else if (level == LW'(DEPTH - 1) && !pop_fire)     state_d = FULL;
          else                                               state_d = REQ;
        end
      end
      DRAIN: begin
        if (LINE_START) begin
          addr_d      = START_ADDR;
          remaining_d = WORD_COUNT;
        end
        if (VRAM_RVALID) state_d = (remaining_d != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A restart while requesting drops REQ for one cycle so the address change is clean.
    req_d = (state_d == REQ) && !(LINE_START && state_q == REQ);

    out_valid_d = out_valid_q;
    underflow_d = underflow_q;
    if (LINE_START) begin
      out_valid_d = 1'b0;
      underflow_d = 1'b0;
    end else if (DCLK_EN) begin
      if (level != '0)    out_valid_d = 1'b1;
      else if (words_due) underflow_d = 1'b1;
      else                out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign VRAM_REQ  = req_q;
  assign VRAM_ADDR = addr_q;
  assign OUT_VALID = out_valid_q;
  assign UNDERFLOW = underflow_q;
  assign LEVEL     = level;

endmodule

// File: tb/tb_t9990_line_fetch_fifo.sv
// Scoreboard bench for the line fetch FIFO with a one-outstanding VRAM model.
module tb_t9990_line_fetch_fifo;
  import t9990_pkg::*;

  logic        CLK, RESET_n, DCLK_EN, LINE_START;
  logic [18:0] START_ADDR;
  logic [9:0]  WORD_COUNT;
  logic        VRAM_REQ, VRAM_ACK, VRAM_RVALID;
  logic [18:0] VRAM_ADDR;
  logic [31:0] VRAM_RDATA, OUT;
  logic        OUT_VALID, UNDERFLOW;
  logic [5:0]  LEVEL;

  int checks = 0;
  int errors = 0;
  int lat    = 2;

  logic [18:0] exp_addr[$];
  logic [31:0] data_q[$];
  logic [31:0] exp_out[$];

  t9990_line_fetch_fifo #(
    .BIT_WIDTH (32),
    .DEPTH     (32),
    .ADDR_WIDTH(19),
    .LOW_MARK  (8)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .DCLK_EN(DCLK_EN), .LINE_START(LINE_START),
    .START_ADDR(START_ADDR), .WORD_COUNT(WORD_COUNT),
    .VRAM_REQ(VRAM_REQ), .VRAM_ADDR(VRAM_ADDR), .VRAM_ACK(VRAM_ACK),
    .VRAM_RDATA(VRAM_RDATA), .VRAM_RVALID(VRAM_RVALID),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .UNDERFLOW(UNDERFLOW), .LEVEL(LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // VRAM model: acks only requests the bench expects, returns data after lat cycles.
  initial begin : vram_model
    bit          m_fire;
    logic [18:0] m_addr;
    logic [31:0] rv_data;
    int          rv_cnt;
    m_fire = 1'b0; m_addr = '0; rv_data = '0; rv_cnt = 0;
    VRAM_ACK = 1'b0; VRAM_RVALID = 1'b0; VRAM_RDATA = '0;
    forever begin
      @(negedge CLK);
      m_fire = VRAM_REQ && VRAM_ACK && RESET_n;
      m_addr = VRAM_ADDR;
      @(posedge CLK);
      #1;
      VRAM_RVALID = 1'b0;
      if (m_fire) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL vram_addr: got 0x%0h with no request expected", m_addr);
        end else begin
          chk("vram_addr", m_addr, exp_addr.pop_front());
        end
        rv_data = (data_q.size() != 0) ? data_q.pop_front() : 32'h0;
        rv_cnt  = lat;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          VRAM_RVALID = 1'b1;
          VRAM_RDATA  = rv_data;
        end
      end
      VRAM_ACK = VRAM_REQ && (exp_addr.size() != 0);
    end
  end

  initial begin : monitor
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge CLK);
      if (pend && RESET_n) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_word: got 0x%0h with no word expected", OUT);
        end else begin
          chk("out_word", OUT, exp_out.pop_front());
          chk("out_valid", OUT_VALID, 1);
        end
      end
      pend = DCLK_EN && !LINE_START && RESET_n && (LEVEL != 0);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic line_start(input logic [18:0] a, input logic [9:0] c);
    LINE_START = 1'b1; START_ADDR = a; WORD_COUNT = c;
    cyc();
    LINE_START = 1'b0;
  endtask

  task automatic push_word(input logic [18:0] a, input logic [31:0] d, input bit vis);
    exp_addr.push_back(a);
    data_q.push_back(d);
    if (vis) exp_out.push_back(d);
  endtask

  task automatic pop_n(input int n);
    DCLK_EN = 1'b1;
    repeat (n) cyc();
    DCLK_EN = 1'b0;
  endtask

  task automatic wait_level(input int lvl, input int budget, input string nm);
    int k;
    k = 0;
    while (LEVEL != 6'(lvl) && k < budget) begin cyc(); k++; end
    checks++;
    if (LEVEL != 6'(lvl)) begin
      errors++;
      $display("FAIL %s: level 0x%0h expected 0x%0h within %0d cycles", nm, LEVEL, lvl, budget);
    end
  endtask

  task automatic wait_out_empty(input int budget, input string nm);
    int k;
    k = 0;
    while (exp_out.size() != 0 && k < budget) begin cyc(); k++; end
    checks++;
    if (exp_out.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words outstanding expected 0", nm, exp_out.size());
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    cyc();
    RESET_n = 1'b1;
  endtask

  initial begin : stim
    RESET_n = 1'b0; DCLK_EN = 1'b0; LINE_START = 1'b0; START_ADDR = '0; WORD_COUNT = '0;
    repeat (3) cyc();
    chk("rst_req", VRAM_REQ, 0);
    chk("rst_addr", VRAM_ADDR, 0);
    chk("rst_out", OUT, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_underflow", UNDERFLOW, 0);
    chk("rst_level", LEVEL, 0);
    RESET_n = 1'b1;
    cyc();

    // Basic line of four words
    lat = 2;
    for (int i = 0; i < 4; i++) push_word(19'h100 + 19'(i), 32'hA0 + 32'(i), 1'b1);
    line_start(19'h100, 10'd4);
    wait_level(4, 100, "basic_level");
    pop_n(4);
    cyc();
    wait_out_empty(5, "basic_words");
    chk("basic_out_valid", OUT_VALID, 1);
    chk("basic_underflow", UNDERFLOW, 0);
    chk("basic_idle", dut.state_q, IDLE);
    chk("basic_level0", LEVEL, 0);
    pop_n(1);
    chk("done_pop_valid", OUT_VALID, 0);
    chk("done_pop_out", OUT, 32'hA3);
    chk("done_pop_underflow", UNDERFLOW, 0);

    // Fill to DEPTH and refill hysteresis
    for (int i = 0; i < 40; i++) push_word(19'h1000 + 19'(i), 32'h1000_0000 + 32'(i), 1'b1);
    line_start(19'h1000, 10'd40);
    wait_level(32, 500, "fill_level");
    repeat (10) cyc();
    chk("full_level", LEVEL, 32);
    chk("full_no_req", VRAM_REQ, 0);
    pop_n(23);
    repeat (4) cyc();
    chk("mark9_level", LEVEL, 9);
    chk("mark9_no_req", VRAM_REQ, 0);
    pop_n(1);
    cyc();
    chk("mark8_level", LEVEL, 8);
    chk("mark8_req", VRAM_REQ, 1);
    wait_level(16, 200, "refill_level");
    pop_n(16);
    cyc();
    wait_out_empty(5, "fill_words");
    chk("fill_underflow", UNDERFLOW, 0);

    // Underflow with slow VRAM
    do_reset();
    lat = 20;
    push_word(19'h300, 32'h3000_0001, 1'b1);
    push_word(19'h301, 32'h3000_0002, 1'b1);
    line_start(19'h300, 10'd2);
    DCLK_EN = 1'b1;
    repeat (5) cyc();
    chk("uf_flag", UNDERFLOW, 1);
    chk("uf_out_hold", OUT, 0);
    chk("uf_level", LEVEL, 0);
    wait_out_empty(200, "uf_words");
    chk("uf_sticky", UNDERFLOW, 1);
    DCLK_EN = 1'b0;
    cyc();

    // Zero-count line only flushes
    line_start(19'h0AB, 10'd0);
    chk("zero_uf_clear", UNDERFLOW, 0);
    chk("zero_valid_clear", OUT_VALID, 0);
    repeat (5) cyc();
    chk("zero_no_req", VRAM_REQ, 0);
    chk("zero_level", LEVEL, 0);

    // Abort while waiting for data
    lat = 6;
    push_word(19'h400, 32'h0000_DEAD, 1'b0);
    line_start(19'h400, 10'd3);
    begin
      int k;
      k = 0;
      while (!VRAM_REQ && k < 20) begin cyc(); k++; end
      chk("abort_req_seen", VRAM_REQ, 1);
    end
    cyc();
    cyc();
    push_word(19'h200, 32'h55AA_0200, 1'b1);
    line_start(19'h200, 10'd1);
    wait_level(1, 100, "abort_level");
    repeat (10) cyc();
    chk("abort_level_hold", LEVEL, 1);
    pop_n(1);
    cyc();
    wait_out_empty(5, "abort_words");

    // Address wrap
    lat = 3;
    push_word(19'h7FFFF, 32'h7000_0001, 1'b1);
    push_word(19'h00000, 32'h7000_0002, 1'b1);
    line_start(19'h7FFFF, 10'd2);
    wait_level(2, 100, "wrap_level");
    pop_n(2);
    cyc();
    wait_out_empty(5, "wrap_words");

    // Reset while stalled in REQ with five words buffered
    lat = 2;
    for (int i = 0; i < 5; i++) push_word(19'h500 + 19'(i), 32'h5000_0000 + 32'(i), 1'b0);
    line_start(19'h500, 10'd10);
    wait_level(5, 100, "mid_level");
    repeat (3) cyc();
    chk("mid_req", VRAM_REQ, 1);
    do_reset();
    chk("mid_rst_req", VRAM_REQ, 0);
    chk("mid_rst_level", LEVEL, 0);
    chk("mid_rst_out", OUT, 0);
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_idle", dut.state_q, IDLE);

    repeat (3) cyc();
    chk("end_addr_queue", exp_addr.size(), 0);
    chk("end_out_queue", exp_out.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t9990_line_fetch_fifo.md
Name: t9990_line_fetch_fifo

Overview:
- VRAM-side producer for the dot-rate pixel path. Issues single-word VRAM read requests for one display line and buffers the returned words in a small FIFO.
- The dot-clock consumer pops one word per DCLK_EN.
- It is the writer/refill end of the dot-rate buffering: it keeps downstream per-dot stages fed from bursty, variable-latency VRAM reads.

Parameters:
- BIT_WIDTH, 32, width of one fetched VRAM word and of OUT.
- DEPTH, 32, FIFO entries; power of two, 4..64.
- ADDR_WIDTH, 19, VRAM word address width.
- LOW_MARK, 8, refill hysteresis: after the FIFO fills, fetching resumes only when LEVEL <= LOW_MARK.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET_n  in  1  reset, synchronous and active-low.
- DCLK_EN  in  1  dot-clock enable; pop strobe.
- LINE_START  in  1  one-cycle pulse; flushes the FIFO and begins a new line fetch.
- START_ADDR  in  ADDR_WIDTH  first VRAM word address of the line; sampled on LINE_START.
- WORD_COUNT  in  10  words to fetch for the line; sampled on LINE_START; 0 means none.
- VRAM_REQ  out  1  read request; held high until VRAM_ACK.
- VRAM_ADDR  out  ADDR_WIDTH  request address; stable while VRAM_REQ is high.
- VRAM_ACK  in  1  request accepted this cycle.
- VRAM_RDATA  in  BIT_WIDTH  read data.
- VRAM_RVALID  in  1  VRAM_RDATA valid; exactly one pulse per acked request, at least 1 cycle after VRAM_ACK.
- OUT  out  BIT_WIDTH  current dot word (registered).
- OUT_VALID  out  1  OUT holds a word popped for this line.
- UNDERFLOW  out  1  sticky flag: a pop was attempted while the FIFO was empty and words were still due.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RESET_n low at a CLK edge):
  - FSM goes to IDLE.
  - VRAM_REQ=0, VRAM_ADDR=0, OUT=0, OUT_VALID=0, UNDERFLOW=0, LEVEL=0.
  - Read and write pointers are 0; remaining-word counter is 0.
  - Reset overrides every other input in the same cycle.
- FIFO storage:
  - Plain RAM array, not reset.
  - Pointers wrap modulo DEPTH.
  - LEVEL is 0..DEPTH inclusive.
- FSM states: IDLE, REQ, WAIT, FULL, DRAIN.
  - IDLE:
    - On LINE_START with WORD_COUNT>0: latch START_ADDR into VRAM_ADDR, latch WORD_COUNT into remaining, go to REQ.
    - On LINE_START with WORD_COUNT=0: flush only and stay in IDLE.
  - REQ:
    - VRAM_REQ=1.
    - On VRAM_ACK: VRAM_ADDR += 1 (wraps modulo 2^ADDR_WIDTH), remaining -= 1, go to WAIT.
  - WAIT:
    - VRAM_REQ=0.
    - On VRAM_RVALID: push VRAM_RDATA.
    - Next state after the push, using the post-push LEVEL:
      - remaining=0 -> IDLE;
      - LEVEL=DEPTH -> FULL;
      - otherwise -> REQ.
  - FULL:
    - No request.
    - When LEVEL <= LOW_MARK: go to REQ if remaining>0, else IDLE.
  - DRAIN:
    - Entered when LINE_START arrives in WAIT, or in REQ in the same cycle as VRAM_ACK.
    - The new START_ADDR/WORD_COUNT are latched at that LINE_START.
    - The next VRAM_RVALID is discarded (no push).
    - Then go to REQ, or to IDLE if the latched count is 0.
  - LINE_START in REQ without VRAM_ACK: VRAM_REQ drops for one cycle, the new address is latched, and the FSM stays in REQ.
  - LINE_START in FULL: as in IDLE.
- Flush on LINE_START (all states):
  - Pointers = 0, LEVEL = 0, OUT_VALID = 0, UNDERFLOW = 0.
  - OUT holds its value.
- Pop, on DCLK_EN when LINE_START is not asserted:
  - LEVEL>0: OUT <= mem[rd], rd += 1, OUT_VALID=1. Latency is 1 CLK from the DCLK_EN cycle.
  - LEVEL=0 and words still due (remaining>0 or FSM in REQ/WAIT): OUT holds and UNDERFLOW is set.
  - LEVEL=0, line complete: OUT holds, OUT_VALID=0, no underflow.
- Simultaneous push and pop: LEVEL is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle; there is no bypass.
- Never push when LEVEL=DEPTH. The FSM guarantees this, since only one request is ever outstanding and FULL blocks requests.

Decomposition:
- Shared t9990 package:
  - fetch_state_t enum (IDLE, REQ, WAIT, FULL, DRAIN);
  - T9990_VRAM_ADDR_WIDTH constant;
  - T9990_WORD_WIDTH constant.
- One sub-module: t9990_sync_fifo (RAM array, pointers, LEVEL, registered read port).
- The fetch FSM stays in the top-level module.

Test Plan:
- Basic line: START_ADDR=0x00100, WORD_COUNT=4, ACK immediately, RVALID 2 cycles after each ACK, data 0xA0..0xA3 -> VRAM_ADDR sequence 0x100..0x103; after 4 DCLK_EN pops OUT=0xA0,0xA1,0xA2,0xA3; OUT_VALID=1; UNDERFLOW=0; FSM back in IDLE.
- Fill/hysteresis: WORD_COUNT=40, no pops -> LEVEL stops at 32 with VRAM_REQ=0; pop 23 words -> no request at LEVEL=9; request reasserts at LEVEL=8; all 40 words eventually delivered in order.
- Underflow: WORD_COUNT=2, RVALID delayed 20 cycles, DCLK_EN every cycle -> UNDERFLOW=1, OUT holds 0; after the data arrives, pops return the words in order and UNDERFLOW stays 1 until the next LINE_START.
- Abort mid-fetch: LINE_START in WAIT with new START_ADDR=0x00200, WORD_COUNT=1; stale RVALID data 0xDEAD -> 0xDEAD never appears on OUT; next request uses address 0x200; LEVEL reaches 1.
- Address wrap and zero count: START_ADDR=0x7FFFF, WORD_COUNT=2 -> requests to 0x7FFFF then 0x00000. WORD_COUNT=0 -> no VRAM_REQ, LEVEL=0.
- Reset mid-operation: RESET_n low for 1 cycle while in REQ with LEVEL=5 -> next cycle VRAM_REQ=0, LEVEL=0, OUT=0, OUT_VALID=0, FSM in IDLE.
